// File: rtl/issue_sched_if.sv
// Decode-to-execute issue port for issue_sched. The decoder side (master) presents one
// instruction per cycle and observes stall/fire and the multiply writeback stream.
interface issue_sched_if;
  logic       issue_valid;
  logic [4:0] issue_r1;
  logic [4:0] issue_r2;
  logic       issue_use_r1;
  logic       issue_use_r2;
  logic [4:0] issue_dst;
  logic       issue_flag_reg;
  logic       issue_flag_mul;
  logic       issue_serial;
  logic       flush;
  logic       stall;
  logic       issue_fire;
  logic       mul_busy;
  logic       mul_wb_valid;
  logic [4:0] mul_wb_dst;

  modport master (
    output issue_valid, issue_r1, issue_r2, issue_use_r1, issue_use_r2, issue_dst,
           issue_flag_reg, issue_flag_mul, issue_serial, flush,
    input  stall, issue_fire, mul_busy, mul_wb_valid, mul_wb_dst
  );

  modport slave (
    input  issue_valid, issue_r1, issue_r2, issue_use_r1, issue_use_r2, issue_dst,
           issue_flag_reg, issue_flag_mul, issue_serial, flush,
    output stall, issue_fire, mul_busy, mul_wb_valid, mul_wb_dst
  );
endinterface

// File: rtl/issue_sched.sv
// Issue scheduler: tracks multiplies in flight, stalls decode on RAW/WAW hazards against
// pending multiply destinations, reserves the register-file write port for multiplies and
// serialises iret/tlbwrite behind outstanding multiplies.
// Optional: define ISSUE_SCHED_PERF_EN to add saturating stall performance counters.
module issue_sched #(
  parameter int unsigned N_STAGES  = 8,
  parameter int unsigned SHORT_LAT = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  issue_sched_if.slave iss
`ifdef ISSUE_SCHED_PERF_EN
  ,
  output logic [31:0]  perf_hazard_stalls,
  output logic [31:0]  perf_wbport_stalls
`endif
);

  // Tracker position whose multiply writes back exactly when a short writer issued now would.
  localparam int unsigned WbPos = N_STAGES - SHORT_LAT;
  // A reader issued while the producer sits in the last two positions reads the register
  // file no earlier than the writeback cycle and gets the value by write-through.
  localparam int RawLast = int'(N_STAGES) - 2;

  logic [N_STAGES:1] trk_vld_q;
  logic [4:0]        trk_dst_q [1:N_STAGES];

  logic raw_haz;
  logic waw_haz;
  logic wbp_haz;
  logic ser_haz;
  logic busy;
  logic fire;
  logic stall;
  logic mul_enter;

  // Hazard detection against the tracker contents.
  always_comb begin
    raw_haz = 1'b0;
    waw_haz = 1'b0;
    for (int i = 1; i <= int'(N_STAGES); i++) begin
      if (trk_vld_q[i]) begin
        if (i <= RawLast) begin
          if (iss.issue_use_r1 && (iss.issue_r1 != 5'd0) && (iss.issue_r1 == trk_dst_q[i])) begin
            raw_haz = 1'b1;
          end
          if (iss.issue_use_r2 && (iss.issue_r2 != 5'd0) && (iss.issue_r2 == trk_dst_q[i])) begin
            raw_haz = 1'b1;
          end
        end
        if (iss.issue_flag_reg && !iss.issue_flag_mul && (iss.issue_dst != 5'd0) &&
            (iss.issue_dst == trk_dst_q[i])) begin
          waw_haz = 1'b1;
        end
      end
    end
  end

  // Remaining stall causes, stall/fire decisions and outputs.
  always_comb begin
    busy      = |trk_vld_q;
    wbp_haz   = iss.issue_flag_reg & ~iss.issue_flag_mul & trk_vld_q[WbPos];
    ser_haz   = iss.issue_serial & busy;
    stall     = rst_n & iss.issue_valid & (raw_haz | waw_haz | wbp_haz | ser_haz);
    fire      = rst_n & iss.issue_valid & ~stall & ~iss.flush;
    mul_enter = fire & iss.issue_flag_mul & iss.issue_flag_reg;
  end

  assign iss.stall        = stall;
  assign iss.issue_fire   = fire;
  assign iss.mul_busy     = busy;
  assign iss.mul_wb_valid = trk_vld_q[N_STAGES];
  assign iss.mul_wb_dst   = trk_dst_q[N_STAGES];

  // Multiply tracker: free-running shift register, new multiply enters at position 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trk_vld_q <= '0;
      for (int i = 1; i <= int'(N_STAGES); i++) begin
        trk_dst_q[i] <= 5'd0;
      end
    end else begin
      trk_vld_q[1] <= mul_enter;
      trk_dst_q[1] <= mul_enter ? iss.issue_dst : 5'd0;
      for (int i = 2; i <= int'(N_STAGES); i++) begin
        trk_vld_q[i] <= trk_vld_q[i-1];
        trk_dst_q[i] <= trk_dst_q[i-1];
      end
    end
  end

`ifdef ISSUE_SCHED_PERF_EN
  logic hazard_cause;
  logic wbp_only;

  always_comb begin
    hazard_cause = stall & (raw_haz | waw_haz | ser_haz);
    wbp_only     = stall & wbp_haz & ~(raw_haz | waw_haz | ser_haz);
  end

  // Saturating stall counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_hazard_stalls <= 32'd0;
      perf_wbport_stalls <= 32'd0;
    end else begin
      if (hazard_cause && (perf_hazard_stalls != 32'hffff_ffff)) begin
        perf_hazard_stalls <= perf_hazard_stalls + 32'd1;
      end
      if (wbp_only && (perf_wbport_stalls != 32'hffff_ffff)) begin
        perf_wbport_stalls <= perf_wbport_stalls + 32'd1;
      end
    end
  end
`endif

endmodule
